// File: rtl/traffic_ctrl.sv
// Two-street traffic light controller with pedestrian walk phase.
// Green dwell is traffic-extended; yellow, all-red and walk are fixed-length.
module traffic_ctrl #(
    parameter int MIN_GRN  = 10,
    parameter int YEL_CYC  = 3,
    parameter int ALLRED   = 2,
    parameter int WALK_CYC = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ta,
    input  logic       tb,
    input  logic       ped_req,
    output logic [1:0] la,
    output logic [1:0] lb,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        AG   = 3'd0,
        AY   = 3'd1,
        ARR  = 3'd2,
        BG   = 3'd3,
        BY   = 3'd4,
        BRR  = 3'd5,
        WALK = 3'd6
    } state_t;

    localparam logic [7:0] GRN_LAST  = 8'(MIN_GRN - 1);
    localparam logic [7:0] YEL_LAST  = 8'(YEL_CYC - 1);
    localparam logic [7:0] RED_LAST  = 8'(ALLRED - 1);
    localparam logic [7:0] WALK_LAST = 8'(WALK_CYC - 1);

    state_t     cur;
    state_t     nxt;
    logic [7:0] cnt;
    logic       ped_pend;
    logic       last_a;
    logic       enter_walk;

    function automatic logic [1:0] light_a(input state_t s);
        case (s)
            AG:      light_a = 2'b00;
            AY:      light_a = 2'b01;
            default: light_a = 2'b10;
        endcase
    endfunction

    function automatic logic [1:0] light_b(input state_t s);
        case (s)
            BG:      light_b = 2'b00;
            BY:      light_b = 2'b01;
            default: light_b = 2'b10;
        endcase
    endfunction

    always_comb begin
        nxt = cur;
        case (cur)
            AG:   if (cnt >= GRN_LAST && (!ta || ped_pend)) nxt = AY;
            AY:   if (cnt == YEL_LAST) nxt = ARR;
            ARR:  if (cnt == RED_LAST) nxt = ped_pend ? WALK : BG;
            BG:   if (cnt >= GRN_LAST && (!tb || ped_pend)) nxt = BY;
            BY:   if (cnt == YEL_LAST) nxt = BRR;
            BRR:  if (cnt == RED_LAST) nxt = ped_pend ? WALK : AG;
            WALK: if (cnt == WALK_LAST) nxt = last_a ? BG : AG;
            default: nxt = AG;  // illegal code 7 recovers to AG
        endcase
    end

    assign enter_walk = (nxt == WALK) && (cur != WALK);

    // Light outputs are registered from the next state so they line up with state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur      <= AG;
            cnt      <= 8'd0;
            ped_pend <= 1'b0;
            last_a   <= 1'b0;
            ped_ack  <= 1'b0;
            la       <= 2'b00;
            lb       <= 2'b10;
            walk     <= 1'b0;
        end else begin
            cur <= nxt;
            if (nxt != cur)
                cnt <= 8'd0;
            else if (cnt != 8'hFF)
                cnt <= cnt + 8'd1;

            if (cur == ARR && nxt != ARR)
                last_a <= 1'b1;
            else if (cur == BRR && nxt != BRR)
                last_a <= 1'b0;

            if (enter_walk)
                ped_pend <= 1'b0;
            else if (ped_req && cur != WALK)
                ped_pend <= 1'b1;

            ped_ack <= enter_walk;
            la      <= light_a(nxt);
            lb      <= light_b(nxt);
            walk    <= (nxt == WALK);
        end
    end

    assign state = cur;

endmodule
